pipe_scheduler: RTL and testbench
=================================

Name: pipe_scheduler

Overview:
- Sequencer for the scrolling pipe datapath.
- Decides when the pipe field advances (scroll_step pulses) and when a new pipe is spawned into a free slot, with a pseudo-random gap height.
- Ramps scroll speed with score.
- Sits between the game FSM / game-tick divider and the pipe shifter, which consumes spawn requests over a valid/ready handshake.

Parameters:
NUM_PIPES, 4, number of pipe slots (2..8)
PIPE_SPACING, 200, scroll steps between consecutive spawns
Y_MIN, 100, lowest gap-top position (pixels)
Y_MAX, 380, exclusive upper bound of gap-top; Y_MAX-Y_MIN must lie in 256..511
DIV_INIT, 8, game ticks per scroll step at level 0
DIV_MIN, 2, fastest ticks per scroll step
SPEEDUP_EVERY, 5, pipes passed per level increase
LFSR_SEED, 10'h2A5, nonzero LFSR reset value

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset; synchronous, active-low
tick_en  in  1  one-cycle game-tick strobe
game_state  in  4  0=IDLE, 1=PLAY, 2=PAUSE, 3=DEAD; other values treated as IDLE
score_inc  in  1  one-cycle pulse per pipe passed
retire_valid  in  1  pipe shifter reports a slot left screen
retire_slot  in  3  slot index being retired
spawn_valid  out  1  spawn request pending
spawn_ready  in  1  shifter accepts spawn this cycle
spawn_slot  out  3  slot to load
spawn_y  out  10  gap-top Y for the new pipe
scroll_step  out  1  one-cycle pulse: shift all active pipes one step
active_mask  out  NUM_PIPES  slot occupancy
level  out  4  current difficulty level

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, state IDLE, LFSR=LFSR_SEED, cur_div=DIV_INIT, tick_cnt=0, dist=PIPE_SPACING, pass_cnt=0.
- LFSR: 10-bit Fibonacci, taps 10,7, advances every cycle regardless of state.
- FSM states: IDLE, RUN, HOLD, DRAIN.
  - IDLE -> RUN when game_state=PLAY. IDLE clears active_mask, level, counters; dist is preset to PIPE_SPACING so the first spawn is requested on the first RUN cycle.
  - RUN -> HOLD on PAUSE; RUN -> DRAIN on DEAD; RUN -> IDLE on IDLE.
  - HOLD -> RUN on PLAY; HOLD -> DRAIN on DEAD; HOLD -> IDLE on IDLE.
  - DRAIN -> IDLE on IDLE only.
- RUN, scroll: on tick_en, tick_cnt increments. When tick_cnt = cur_div-1, tick_cnt wraps to 0 and scroll_step pulses for exactly that cycle (registered, 1-cycle latency from tick_en). dist increments, saturating at PIPE_SPACING.
- Spawn request:
  - Condition: RUN, dist >= PIPE_SPACING, spawn_valid=0, at least one active_mask bit clear.
  - Action: assert spawn_valid next cycle. spawn_slot = lowest clear index. spawn_y = Y_MIN + f(lfsr[8:0]), where f(v) = v if v < (Y_MAX-Y_MIN), else v-(Y_MAX-Y_MIN).
  - slot and y are latched and held stable while valid is high.
  - No free slot: no request; dist stays saturated; re-check each cycle.
- Handshake: transfer when spawn_valid & spawn_ready. Same edge: spawn_valid=0, active_mask[slot]=1, dist=0. spawn_ready while valid=0 is ignored.
  - In HOLD, spawn_valid stays asserted and stable; scroll_step is suppressed and tick_cnt frozen.
  - Entering DRAIN or IDLE withdraws spawn_valid unconditionally; these are the only permitted withdrawals besides reset.
- Retire: retire_valid clears active_mask[retire_slot] in any state.
  - Out-of-range index (>= NUM_PIPES) is ignored.
  - Retire and spawn-accept on the same slot in the same cycle: spawn wins (bit=1).
  - A slot freed this cycle becomes eligible for spawn next cycle.
- Difficulty: score_inc in RUN/HOLD increments pass_cnt. When pass_cnt reaches SPEEDUP_EVERY, it returns to 0, level increments (saturates at 15) and cur_div decrements (saturates at DIV_MIN). The new cur_div applies from the next scroll period; if tick_cnt >= new cur_div, tick_cnt resets to 0.
- DRAIN: no scroll_step, no spawns, active_mask and level retained for display.

Optional Feature:
- Macro: PIPE_SCHED_RAMP_EN.
- Defined: difficulty ramp as above.
- Undefined: pass_cnt/level logic removed, level tied to 0, cur_div constant DIV_INIT, score_inc ignored.

Test Plan:
- Reset then game_state=1, spawn_ready=1: spawn_valid rises 1 cycle after entering RUN with spawn_slot=0, spawn_y in 100..379; active_mask=4'b0001 after accept.
- tick_en every cycle, DIV_INIT=8: scroll_step once per 8 ticks. Second spawn request after 200 steps, slot=1.
- spawn_ready=0 with valid high, then game_state=2 for 50 cycles: spawn_valid, spawn_slot, spawn_y unchanged, no scroll_step. Return to 1, raise ready: accepted, dist=0.
- All 4 slots active: no spawn_valid. retire_valid with slot 2: spawn_slot=2 requested next eligible cycle. Same-cycle retire+accept on one slot leaves bit set.
- 10 score_inc pulses (macro defined): level=2, scroll period 6 ticks. 40 pulses: level=8, period clamps at 2. Macro undefined: level stays 0, period 8.
- game_state=3 with valid pending: spawn_valid drops next cycle, active_mask held. game_state=0: mask=0, level=0. rst low mid-RUN: all outputs 0 on the next edge.

Source files
------------

// File: rtl/pipe_scheduler.sv
// pipe_scheduler: sequencer for the scrolling pipe field.
// Produces scroll_step pulses from the game tick, requests new pipes into
// free slots over a valid/ready handshake with a pseudo-random gap height,
// and tracks slot occupancy.
// Optional difficulty ramp (level / faster scroll with score) is enabled by
// defining PIPE_SCHED_RAMP_EN; without it level is 0 and the scroll divider
// is fixed at DIV_INIT.
module pipe_scheduler #(
    parameter int         NUM_PIPES     = 4,
    parameter int         PIPE_SPACING  = 200,
    parameter int         Y_MIN         = 100,
    parameter int         Y_MAX         = 380,
    parameter int         DIV_INIT      = 8,
    parameter int         DIV_MIN       = 2,
    parameter int         SPEEDUP_EVERY = 5,
    parameter logic [9:0] LFSR_SEED     = 10'h2A5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_en,
    input  logic [3:0]           game_state,
    input  logic                 score_inc,
    input  logic                 retire_valid,
    input  logic [2:0]           retire_slot,
    output logic                 spawn_valid,
    input  logic                 spawn_ready,
    output logic [2:0]           spawn_slot,
    output logic [9:0]           spawn_y,
    output logic                 scroll_step,
    output logic [NUM_PIPES-1:0] active_mask,
    output logic [3:0]           level
);

    localparam int DSTW = $clog2(PIPE_SPACING + 1);
    localparam int DVW  = $clog2(DIV_INIT + 1);

    localparam logic [DSTW-1:0] SPACING = DSTW'(PIPE_SPACING);
    localparam logic [DVW-1:0]  DIV_I   = DVW'(DIV_INIT);
    localparam logic [8:0]      Y_RANGE = 9'(Y_MAX - Y_MIN);
    localparam logic [9:0]      Y_BASE  = 10'(Y_MIN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DRAIN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [9:0]             r_lfsr;
    logic [DVW-1:0]         r_tick_cnt, w_tick_nxt;
    logic                   r_scroll;
    logic [DSTW-1:0]        r_dist;
    logic                   r_spawn_valid;
    logic [2:0]             r_spawn_slot;
    logic [9:0]             r_spawn_y;
    logic [NUM_PIPES-1:0]   r_mask, w_mask_nxt;

    logic                   w_gs_play, w_gs_pause, w_gs_dead, w_gs_idle;
    logic                   w_run, w_tick_wrap, w_accept, w_spawn_req, w_leave;
    logic                   w_free_any;
    logic [2:0]             w_free_idx;
    logic [8:0]             w_y_off;
    logic [9:0]             w_y;
    logic                   w_speedup;
    logic [DVW-1:0]         w_cur_div, w_div_nxt;
    logic [3:0]             w_level;

    // Unlisted game_state encodings fall back to IDLE.
    assign w_gs_play  = (game_state == 4'd1);
    assign w_gs_pause = (game_state == 4'd2);
    assign w_gs_dead  = (game_state == 4'd3);
    assign w_gs_idle  = !(w_gs_play || w_gs_pause || w_gs_dead);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state decode from the game FSM's state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_gs_play) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_gs_pause)     w_state_nxt = S_HOLD;
                else if (w_gs_dead) w_state_nxt = S_DRAIN;
                else if (w_gs_idle) w_state_nxt = S_IDLE;
            end
            S_HOLD: begin
                if (w_gs_play)      w_state_nxt = S_RUN;
                else if (w_gs_dead) w_state_nxt = S_DRAIN;
                else if (w_gs_idle) w_state_nxt = S_IDLE;
            end
            S_DRAIN: if (w_gs_idle) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Lowest clear slot index is the spawn target.
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_PIPES - 1; i >= 0; i--) begin
            if (!r_mask[i]) begin
                w_free_any = 1'b1;
                w_free_idx = 3'(i);
            end
        end
    end

    // Fold the 9-bit LFSR sample into [0, Y_RANGE); one subtract suffices
    // because Y_RANGE >= 256.
    assign w_y_off = (r_lfsr[8:0] < Y_RANGE) ? r_lfsr[8:0] : r_lfsr[8:0] - Y_RANGE;
    assign w_y     = Y_BASE + {1'b0, w_y_off};

    assign w_run       = (r_state == S_RUN);
    assign w_tick_wrap = w_run && tick_en && (r_tick_cnt == w_cur_div - DVW'(1));
    assign w_accept    = r_spawn_valid && spawn_ready;
    assign w_spawn_req = w_run && (r_dist >= SPACING) && !r_spawn_valid && w_free_any;
    assign w_leave     = (w_state_nxt == S_DRAIN) || (w_state_nxt == S_IDLE);

`ifdef PIPE_SCHED_RAMP_EN
    logic [$clog2(SPEEDUP_EVERY+1)-1:0] r_pass_cnt;
    logic [3:0]                         r_level;
    logic [DVW-1:0]                     r_cur_div;
    logic                               w_score;

    assign w_score   = score_inc && (r_state == S_RUN || r_state == S_HOLD);
    assign w_speedup = w_score && (r_pass_cnt == ($clog2(SPEEDUP_EVERY+1))'(SPEEDUP_EVERY - 1));
    assign w_div_nxt = (w_speedup && r_cur_div > DVW'(DIV_MIN)) ? r_cur_div - DVW'(1) : r_cur_div;
    assign w_cur_div = r_cur_div;
    assign w_level   = r_level;

    // Difficulty: every SPEEDUP_EVERY pipes raises level and shortens the scroll period.
    always_ff @(posedge clk) begin
        if (!rst || r_state == S_IDLE) begin
            r_pass_cnt <= '0;
            r_level    <= '0;
            r_cur_div  <= DIV_I;
        end else if (w_score) begin
            if (w_speedup) begin
                r_pass_cnt <= '0;
                if (r_level != 4'hF) r_level <= r_level + 4'd1;
                r_cur_div  <= w_div_nxt;
            end else begin
                r_pass_cnt <= r_pass_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unused_score;
    assign w_unused_score = score_inc;
    assign w_speedup      = 1'b0;
    assign w_div_nxt      = DIV_I;
    assign w_cur_div      = DIV_I;
    assign w_level        = 4'd0;
`endif

    // Tick counter advances only in RUN; a shortened divider pulls an
    // out-of-range count back to 0 so the next period starts cleanly.
    always_comb begin
        w_tick_nxt = r_tick_cnt;
        if (r_state == S_IDLE)     w_tick_nxt = '0;
        else if (w_run && tick_en) w_tick_nxt = w_tick_wrap ? '0 : r_tick_cnt + DVW'(1);
        if (w_speedup && w_tick_nxt >= w_div_nxt) w_tick_nxt = '0;
    end

    // Occupancy: retire clears, accept sets afterwards so it wins on a tie.
    always_comb begin
        w_mask_nxt = r_mask;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (retire_valid && retire_slot == 3'(i)) w_mask_nxt[i] = 1'b0;
        end
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (w_accept && r_spawn_slot == 3'(i)) w_mask_nxt[i] = 1'b1;
        end
    end

    // Datapath registers: LFSR, scroll timing, spawn handshake, occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lfsr        <= LFSR_SEED;
            r_tick_cnt    <= '0;
            r_scroll      <= 1'b0;
            r_dist        <= SPACING;
            r_spawn_valid <= 1'b0;
            r_spawn_slot  <= '0;
            r_spawn_y     <= '0;
            r_mask        <= '0;
        end else begin
            r_lfsr     <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
            r_tick_cnt <= w_tick_nxt;
            r_scroll   <= w_tick_wrap;

            if (r_state == S_IDLE)                 r_dist <= SPACING;
            else if (w_accept)                     r_dist <= '0;
            else if (w_tick_wrap && r_dist < SPACING) r_dist <= r_dist + DSTW'(1);

            // A pending request is only dropped by a transfer or by leaving play.
            if (w_leave || w_accept) begin
                r_spawn_valid <= 1'b0;
            end else if (w_spawn_req) begin
                r_spawn_valid <= 1'b1;
                r_spawn_slot  <= w_free_idx;
                r_spawn_y     <= w_y;
            end

            r_mask <= (r_state == S_IDLE) ? '0 : w_mask_nxt;
        end
    end

    assign spawn_valid = r_spawn_valid;
    assign spawn_slot  = r_spawn_slot;
    assign spawn_y     = r_spawn_y;
    assign scroll_step = r_scroll;
    assign active_mask = r_mask;
    assign level       = w_level;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler with a spawn scoreboard: expected slots
// are queued by the stimulus, the monitor pops one per accepted transfer.
module tb_pipe_scheduler;

    logic       clk = 1'b0;
    logic       rst, tick_en, score_inc, retire_valid, spawn_ready;
    logic [3:0] game_state;
    logic [2:0] retire_slot;
    logic       spawn_valid, scroll_step;
    logic [2:0] spawn_slot;
    logic [9:0] spawn_y;
    logic [3:0] active_mask;
    logic [3:0] level;

`ifdef PIPE_SCHED_RAMP_EN
    localparam int EXP_L1 = 1, EXP_L2 = 2, EXP_L8 = 8, EXP_P2 = 6, EXP_P8 = 2;
`else
    localparam int EXP_L1 = 0, EXP_L2 = 0, EXP_L8 = 0, EXP_P2 = 8, EXP_P8 = 8;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    pipe_scheduler dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .game_state(game_state),
        .score_inc(score_inc), .retire_valid(retire_valid), .retire_slot(retire_slot),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_slot(spawn_slot),
        .spawn_y(spawn_y), .scroll_step(scroll_step), .active_mask(active_mask),
        .level(level)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_score(input int n);
        for (int i = 0; i < n; i++) begin
            score_inc = 1'b1; step(1);
            score_inc = 1'b0; step(1);
        end
    endtask

    task automatic meas_period(output int per);
        int k;
        k = 0;
        while (!scroll_step && k < 60) begin step(1); k++; end
        step(1);
        k = 1;
        while (!scroll_step && k < 60) begin step(1); k++; end
        per = k;
    endtask

    task automatic wait_valid(input int bound);
        int k;
        k = 0;
        while (!spawn_valid && k < bound) begin step(1); k++; end
    endtask

    // Scoreboard monitor: every accepted spawn must match the next queued slot.
    always @(negedge clk) begin : mon
        int e;
        if (rst && spawn_valid && spawn_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_spawn", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_spawn_slot", int'(spawn_slot), e);
                chk("sb_spawn_y_range", int'(spawn_y >= 10'd100 && spawn_y <= 10'd379), 1);
            end
        end
    end

    initial begin : stim
        int cnt, k, first, gap, per, bad;
        logic [2:0] hs;
        logic [9:0] hy;

        rst = 1'b0; tick_en = 1'b0; score_inc = 1'b0; retire_valid = 1'b0;
        retire_slot = '0; spawn_ready = 1'b0; game_state = 4'd0;
        step(3);
        chk("rst_valid", int'(spawn_valid), 0);
        chk("rst_slot",  int'(spawn_slot), 0);
        chk("rst_y",     int'(spawn_y), 0);
        chk("rst_scroll", int'(scroll_step), 0);
        chk("rst_mask",  int'(active_mask), 0);
        chk("rst_level", int'(level), 0);

        // First spawn right after entering RUN
        rst = 1'b1; spawn_ready = 1'b1; step(2);
        chk("idle_no_spawn", int'(spawn_valid), 0);
        game_state = 4'd1; step(1);
        chk("run_entry_valid_low", int'(spawn_valid), 0);
        exp_q.push_back(0);
        step(1);
        chk("first_valid", int'(spawn_valid), 1);
        chk("first_slot", int'(spawn_slot), 0);
        step(1);
        chk("first_mask", int'(active_mask), 1);
        chk("first_valid_drop", int'(spawn_valid), 0);

        // Scroll cadence and spacing to the second spawn
        exp_q.push_back(1);
        tick_en = 1'b1;
        cnt = 0; k = 0; first = -1; gap = -1;
        while (!spawn_valid && k < 2500) begin
            step(1); k++;
            if (scroll_step) begin
                cnt++;
                if (cnt == 1) first = k;
                if (cnt == 2) gap = k - first;
            end
        end
        chk("scroll_gap", gap, 8);
        chk("steps_to_second_spawn", cnt, 200);
        chk("second_slot", int'(spawn_slot), 1);
        step(1);
        chk("second_mask", int'(active_mask), 3);

        // Pause with a pending request
        spawn_ready = 1'b0;
        wait_valid(2000);
        chk("third_valid", int'(spawn_valid), 1);
        chk("third_slot", int'(spawn_slot), 2);
        hs = spawn_slot; hy = spawn_y;
        game_state = 4'd2; step(1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (!spawn_valid || spawn_slot != hs || spawn_y != hy || scroll_step) bad++;
        end
        chk("hold_violations", bad, 0);
        exp_q.push_back(2);
        game_state = 4'd1; spawn_ready = 1'b1; step(1);
        chk("hold_release_valid", int'(spawn_valid), 0);
        chk("third_mask", int'(active_mask), 7);

        // Fill all slots, then no requests
        exp_q.push_back(3);
        k = 0;
        while (active_mask != 4'hF && k < 2000) begin step(1); k++; end
        chk("mask_full", int'(active_mask), 15);
        bad = 0;
        for (int i = 0; i < 1700; i++) begin
            step(1);
            if (spawn_valid) bad++;
        end
        chk("full_no_spawn", bad, 0);

        // Retire slot 2 -> respawn slot 2
        spawn_ready = 1'b0; retire_valid = 1'b1; retire_slot = 3'd2; step(1);
        retire_valid = 1'b0;
        chk("retire_clears", int'(active_mask), 11);
        chk("retire_not_same_cycle", int'(spawn_valid), 0);
        step(1);
        chk("respawn_valid", int'(spawn_valid), 1);
        chk("respawn_slot", int'(spawn_slot), 2);
        exp_q.push_back(2);
        spawn_ready = 1'b1; retire_valid = 1'b1; retire_slot = 3'd2; step(1);
        retire_valid = 1'b0; spawn_ready = 1'b0;
        chk("retire_vs_accept", int'(active_mask), 15);
        retire_valid = 1'b1; retire_slot = 3'd5; step(1);
        retire_valid = 1'b0;
        chk("retire_oob_ignored", int'(active_mask), 15);

        // Difficulty ramp
        pulse_score(10);
        chk("level_after_10", int'(level), EXP_L2);
        step(20);
        meas_period(per);
        chk("period_after_10", per, EXP_P2);
        pulse_score(30);
        chk("level_after_40", int'(level), EXP_L8);
        step(20);
        meas_period(per);
        chk("period_after_40", per, EXP_P8);

        // DEAD withdraws a pending request, keeps the field
        retire_valid = 1'b1; retire_slot = 3'd1; step(1);
        retire_valid = 1'b0;
        wait_valid(2000);
        chk("dead_pre_valid", int'(spawn_valid), 1);
        chk("dead_pre_slot", int'(spawn_slot), 1);
        game_state = 4'd3; step(1);
        chk("dead_withdraw", int'(spawn_valid), 0);
        chk("dead_mask_held", int'(active_mask), 13);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (scroll_step || spawn_valid) bad++;
        end
        chk("drain_quiet", bad, 0);
        chk("drain_level_held", int'(level), EXP_L8);
        game_state = 4'd0; step(2);
        chk("idle_mask_clear", int'(active_mask), 0);
        chk("idle_level_clear", int'(level), 0);

        // Reset in the middle of play
        game_state = 4'd1; spawn_ready = 1'b1;
        exp_q.push_back(0);
        step(3);
        chk("rerun_mask", int'(active_mask), 1);
        spawn_ready = 1'b0;
        pulse_score(5);
        chk("rerun_level", int'(level), EXP_L1);
        rst = 1'b0; step(1);
        chk("midrst_valid", int'(spawn_valid), 0);
        chk("midrst_slot", int'(spawn_slot), 0);
        chk("midrst_y", int'(spawn_y), 0);
        chk("midrst_scroll", int'(scroll_step), 0);
        chk("midrst_mask", int'(active_mask), 0);
        chk("midrst_level", int'(level), 0);
        rst = 1'b1; game_state = 4'd0; step(2);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
